// File: rtl/spi_byte_slave_if.sv
// Bus bundle for spi_byte_slave: raw SPI pins plus the byte-level
// application handshake. The slave modport is the engine's view, the
// master modport is the view of whatever drives the pins and supplies
// tx_data (board pins plus application logic, or a testbench).
interface spi_byte_slave_if #(
  parameter int CNT_W = 8
);
  logic             spi_ncs;
  logic             spi_sck;
  logic             spi_mosi;
  logic             spi_miso;
  logic [7:0]       tx_data;
  logic             tx_taken;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             frame_active;
  logic             frame_done;
  logic [CNT_W-1:0] byte_count;

  modport slave (
    input  spi_ncs, spi_sck, spi_mosi, tx_data,
    output spi_miso, tx_taken, rx_data, rx_valid,
           frame_active, frame_done, byte_count
  );

  modport master (
    output spi_ncs, spi_sck, spi_mosi, tx_data,
    input  spi_miso, tx_taken, rx_data, rx_valid,
           frame_active, frame_done, byte_count
  );
endinterface

// File: rtl/spi_byte_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave byte engine, oversampled
// by sys_clk. Raw SCK/MOSI/nCS are synchronised, SCK and nCS edges are
// detected in the sys_clk domain, MOSI is deserialised on SCK rising
// edges and tx_data is shifted onto MISO on SCK falling edges.
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic                sys_clk,
  input logic                rst_n,
  spi_byte_slave_if.slave    spi_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // SCK and nCS chains carry one extra tap beyond the synchroniser so the
  // last two taps form the edge-detect history. MOSI only needs the
  // synchroniser depth so its output lines up with the newer of those taps.
  logic [SYNC_STAGES:0]   r_sck_sync;
  logic [SYNC_STAGES:0]   r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ncs_fall;
  logic w_ncs_rise;
  logic w_ncs_low;
  logic w_mosi;

  state_t           r_state;
  logic [7:0]       r_tx_sr;
  logic [7:0]       r_rx_sr;
  logic [2:0]       r_bit_cnt;
  logic             r_reload_pend;
  logic             r_byte_done;
  logic             r_fall_pend;
  logic             r_miso;
  logic             r_tx_taken;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_active;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_byte_count;

  // Synchronise the raw pins into sys_clk; reset to 0 so a high nCS at
  // reset exit shows up as a rise, which IDLE ignores.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; = here would collapse the chain.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_ncs_sync  <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-1:0], spi_bus.spi_sck};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-1:0], spi_bus.spi_ncs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_bus.spi_mosi};
    end
  end

  // One-cycle edge strobes from the last two taps.
  assign w_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_sync[SYNC_STAGES];
  assign w_sck_fall = ~r_sck_sync[SYNC_STAGES-1] & r_sck_sync[SYNC_STAGES];
  assign w_ncs_fall = ~r_ncs_sync[SYNC_STAGES-1] & r_ncs_sync[SYNC_STAGES];
  assign w_ncs_rise = r_ncs_sync[SYNC_STAGES-1] & ~r_ncs_sync[SYNC_STAGES];
  assign w_ncs_low  = ~r_ncs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];

  // Frame FSM with all datapath and output registers; pulse outputs
  // default low every cycle and are raised only by the state that owns them.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_tx_sr        <= '0;
      r_rx_sr        <= '0;
      r_bit_cnt      <= '0;
      r_reload_pend  <= 1'b0;
      r_byte_done    <= 1'b0;
      r_fall_pend    <= 1'b0;
      r_miso         <= 1'b0;
      r_tx_taken     <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_byte_count   <= '0;
    end else begin
      r_tx_taken   <= 1'b0;
      r_frame_done <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_byte_done  <= 1'b0;

      // A byte completed on the previous cycle: publish it. This runs in
      // every state so a byte finishing together with nCS rising still
      // reaches rx_data while the FSM is already in DONE.
      if (r_byte_done) begin
        r_rx_data  <= r_rx_sr;
        r_rx_valid <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          // A fall seen during DONE is remembered and honoured here as
          // long as nCS is still low.
          if (w_ncs_fall || (r_fall_pend && w_ncs_low)) begin
            r_state <= S_LOAD;
          end
          r_fall_pend <= 1'b0;
        end

        S_LOAD: begin
          r_tx_sr        <= spi_bus.tx_data;
          r_tx_taken     <= 1'b1;
          r_miso         <= spi_bus.tx_data[7];
          r_bit_cnt      <= '0;
          r_byte_count   <= '0;
          r_frame_active <= 1'b1;
          r_reload_pend  <= 1'b0;
          r_state        <= w_ncs_rise ? S_DONE : S_SHIFT;
        end

        S_SHIFT: begin
          if (w_sck_rise) begin
            r_rx_sr   <= {r_rx_sr[6:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_byte_done   <= 1'b1;
              r_byte_count  <= r_byte_count + CNT_W'(1);
              r_reload_pend <= 1'b1;
            end
          end else if (w_sck_fall) begin
            if (r_reload_pend) begin
              r_tx_sr       <= spi_bus.tx_data;
              r_tx_taken    <= 1'b1;
              r_miso        <= spi_bus.tx_data[7];
              r_reload_pend <= 1'b0;
            end else begin
              r_tx_sr <= {r_tx_sr[6:0], 1'b0};
              r_miso  <= r_tx_sr[6];
            end
          end
          // Partial bits are simply abandoned: bit_cnt is cleared in DONE
          // and rx_data/byte_count are only touched on a complete byte.
          if (w_ncs_rise) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_frame_done   <= 1'b1;
          r_frame_active <= 1'b0;
          r_miso         <= 1'b0;
          r_bit_cnt      <= '0;
          r_reload_pend  <= 1'b0;
          r_fall_pend    <= w_ncs_fall;
          r_state        <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_bus.spi_miso     = r_miso;
  assign spi_bus.tx_taken     = r_tx_taken;
  assign spi_bus.rx_data      = r_rx_data;
  assign spi_bus.rx_valid     = r_rx_valid;
  assign spi_bus.frame_active = r_frame_active;
  assign spi_bus.frame_done   = r_frame_done;
  assign spi_bus.byte_count   = r_byte_count;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed bench for spi_byte_slave: a frame table applied in a loop plus
// hand-written reset, idle-bus and byte-count-wrap sequences. A second
// instance with CNT_W=2 shares the pins for the wrap check.
module tb_spi_byte_slave;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic ncs     = 1'b0;
  logic sck     = 1'b0;
  logic mosi    = 1'b0;
  logic [7:0] tx_cur;

  always #5 sys_clk = ~sys_clk;

  spi_byte_slave_if #(.CNT_W(8)) bus8 ();
  spi_byte_slave_if #(.CNT_W(2)) bus2 ();

  assign bus8.spi_ncs  = ncs;
  assign bus8.spi_sck  = sck;
  assign bus8.spi_mosi = mosi;
  assign bus8.tx_data  = tx_cur;
  assign bus2.spi_ncs  = ncs;
  assign bus2.spi_sck  = sck;
  assign bus2.spi_mosi = mosi;
  assign bus2.tx_data  = tx_cur;

  spi_byte_slave #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .spi_bus (bus8)
  );

  spi_byte_slave #(.SYNC_STAGES(2), .CNT_W(2)) dut_w (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .spi_bus (bus2)
  );

  // ---------------- monitor: event counters and logs ----------------
  int         rx_cnt     = 0;
  int         taken_cnt  = 0;
  int         done_cnt   = 0;
  int         miso_hi    = 0;
  int         wrap_cnt   = 0;
  logic [7:0] rx_log   [64];
  logic [1:0] wrap_log [64];

  // tx_data follows a per-frame sequence, advancing after every tx_taken.
  logic [4:0][7:0] tx_seq = '0;
  int              taken_base = 0;

  always_comb begin
    tx_cur = 8'h00;
    if ((taken_cnt - taken_base) >= 0 && (taken_cnt - taken_base) < 5)
      tx_cur = tx_seq[taken_cnt - taken_base];
  end

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (bus8.rx_valid) begin
        if (rx_cnt < 64) rx_log[rx_cnt] = bus8.rx_data;
        rx_cnt = rx_cnt + 1;
      end
      if (bus8.tx_taken)   taken_cnt = taken_cnt + 1;
      if (bus8.frame_done) done_cnt  = done_cnt + 1;
      if (bus8.spi_miso)   miso_hi   = miso_hi + 1;
      if (bus2.rx_valid) begin
        if (wrap_cnt < 64) wrap_log[wrap_cnt] = bus2.byte_count;
        wrap_cnt = wrap_cnt + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Master side of one frame at SCK = sys_clk/16. nbits may stop short
  // of a byte boundary to abort. MISO is sampled just before each rising
  // SCK edge, as a mode-0 master would.
  task automatic send_frame(input logic [4:0][7:0] mb, input int nbits,
                            output logic [4:0][7:0] got,
                            output logic active_mid);
    got        = '0;
    active_mid = 1'b0;
    ncs = 1'b0;
    clk_wait(12);
    for (int i = 0; i < nbits; i++) begin
      mosi = mb[i/8][7-(i%8)];
      clk_wait(8);
      got[i/8][7-(i%8)] = bus8.spi_miso;
      if (i == 0) active_mid = bus8.frame_active;
      sck = 1'b1;
      clk_wait(8);
      sck = 1'b0;
    end
    clk_wait(8);
    ncs  = 1'b1;
    mosi = 1'b0;
    clk_wait(16);
  endtask

  typedef struct {
    string           name;
    logic [4:0][7:0] mosi;
    logic [4:0][7:0] tx;
    int              nbits;
    int              exp_rx_n;
    int              exp_taken;
    logic [7:0]      exp_bc;
    logic [7:0]      exp_rx_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [4:0][7:0] got;
    logic            act_mid;
    int              rx_base, done_base, miso_base, wrap_base;

    // Frame table: one byte, three bytes, abort after 5 bits, zero byte.
    vecs[0] = '{"single", {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h3C}, 8, 1, 2, 8'd1, 8'hA5};
    vecs[1] = '{"three", {8'h00, 8'h00, 8'hFF, 8'h02, 8'h01},
                {8'h00, 8'h40, 8'h30, 8'h20, 8'h10}, 24, 3, 4, 8'd3, 8'hFF};
    vecs[2] = '{"abort", {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h77}, 5, 0, 1, 8'd0, 8'hFF};
    vecs[3] = '{"zero", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, 8, 1, 2, 8'd1, 8'h00};

    // ---- reset held with nCS low and SCK toggling ----
    rst_n = 1'b0;
    ncs   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sck = ~sck;
      clk_wait(3);
    end
    check("rst_miso",         {31'd0, bus8.spi_miso},     32'd0);
    check("rst_tx_taken",     {31'd0, bus8.tx_taken},     32'd0);
    check("rst_rx_data",      {24'd0, bus8.rx_data},      32'd0);
    check("rst_rx_valid",     {31'd0, bus8.rx_valid},     32'd0);
    check("rst_frame_active", {31'd0, bus8.frame_active}, 32'd0);
    check("rst_frame_done",   {31'd0, bus8.frame_done},   32'd0);
    check("rst_byte_count",   {24'd0, bus8.byte_count},   32'd0);

    // ---- release mid-frame: no activity until nCS rises then falls ----
    sck = 1'b0;
    clk_wait(2);
    rst_n = 1'b1;
    rx_base = rx_cnt;
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      sck  = ~sck;
      clk_wait(8);
    end
    check("post_rst_rx_valid", rx_cnt,    rx_base);
    check("post_rst_taken",    taken_cnt, 0);
    check("post_rst_active",   {31'd0, bus8.frame_active}, 32'd0);
    ncs  = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    clk_wait(16);
    check("post_rst_no_done", done_cnt, 0);

    // ---- SCK/MOSI toggling with nCS high ----
    rx_base = rx_cnt; done_base = done_cnt; miso_base = miso_hi;
    taken_base = taken_cnt;
    for (int i = 0; i < 64; i++) begin
      sck  = ~sck;
      mosi = i[1];
      clk_wait(4);
    end
    sck = 1'b0; mosi = 1'b0;
    clk_wait(8);
    check("idle_miso_high", miso_hi,   miso_base);
    check("idle_rx_valid",  rx_cnt,    rx_base);
    check("idle_tx_taken",  taken_cnt, taken_base);
    check("idle_done",      done_cnt,  done_base);

    // ---- table-driven frames ----
    for (int v = 0; v < 4; v++) begin
      rx_base    = rx_cnt;
      done_base  = done_cnt;
      tx_seq     = vecs[v].tx;
      taken_base = taken_cnt;
      clk_wait(1);
      send_frame(vecs[v].mosi, vecs[v].nbits, got, act_mid);
      check({vecs[v].name, "_active"},  {31'd0, act_mid}, 32'd1);
      check({vecs[v].name, "_rx_n"},    rx_cnt - rx_base, vecs[v].exp_rx_n);
      for (int k = 0; k < vecs[v].exp_rx_n; k++)
        check($sformatf("%s_rx%0d", vecs[v].name, k),
              {24'd0, rx_log[rx_base+k]}, {24'd0, vecs[v].mosi[k]});
      for (int k = 0; k < vecs[v].nbits / 8; k++)
        check($sformatf("%s_miso%0d", vecs[v].name, k),
              {24'd0, got[k]}, {24'd0, vecs[v].tx[k]});
      check({vecs[v].name, "_taken"},   taken_cnt - taken_base, vecs[v].exp_taken);
      check({vecs[v].name, "_bc"},      {24'd0, bus8.byte_count}, {24'd0, vecs[v].exp_bc});
      check({vecs[v].name, "_rx_data"}, {24'd0, bus8.rx_data},    {24'd0, vecs[v].exp_rx_data});
      check({vecs[v].name, "_done"},    done_cnt - done_base, 1);
      check({vecs[v].name, "_inactive"}, {31'd0, bus8.frame_active}, 32'd0);
      check({vecs[v].name, "_miso_idle"}, {31'd0, bus8.spi_miso}, 32'd0);
    end

    // ---- byte_count wrap on the CNT_W=2 instance, 5-byte frame ----
    wrap_base  = wrap_cnt;
    tx_seq     = '0;
    taken_base = taken_cnt;
    send_frame({8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 40, got, act_mid);
    check("wrap_n", wrap_cnt - wrap_base, 5);
    check("wrap_bc0", {30'd0, wrap_log[wrap_base+0]}, 32'd1);
    check("wrap_bc1", {30'd0, wrap_log[wrap_base+1]}, 32'd2);
    check("wrap_bc2", {30'd0, wrap_log[wrap_base+2]}, 32'd3);
    check("wrap_bc3", {30'd0, wrap_log[wrap_base+3]}, 32'd0);
    check("wrap_bc4", {30'd0, wrap_log[wrap_base+4]}, 32'd1);
    check("wide_bc5", {24'd0, bus8.byte_count}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
